// File: rtl/traffic_light_ctrl.sv
// Multi-approach traffic light controller: green/yellow/all-red cycling with
// round-robin demand service, min/max green limits and a flashing-yellow mode.
module traffic_light_ctrl #(
  parameter int unsigned NUM_DIR   = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned GREEN_MIN = 10,
  parameter int unsigned GREEN_MAX = 40,
  parameter int unsigned YELLOW_T  = 4,
  parameter int unsigned ALLRED_T  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_DIR-1:0]         car,
  input  logic                       flash,
  output logic [NUM_DIR-1:0]         green,
  output logic [NUM_DIR-1:0]         yellow,
  output logic [NUM_DIR-1:0]         red,
  output logic [$clog2(NUM_DIR)-1:0] active
);

  localparam int unsigned AW = $clog2(NUM_DIR);
  localparam logic [CNT_W-1:0] MIN_M1  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] MAX_M1  = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] Y_M1    = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] TMR_MAX = '1;
  localparam logic [AW-1:0]    LAST    = AW'(NUM_DIR - 1);

  typedef enum logic [1:0] {ST_G, ST_Y, ST_AR, ST_FL} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [AW-1:0]      dir_q, dir_d;
  logic [AW-1:0]      active_d;
  logic [CNT_W-1:0]   fl_cnt_q, fl_cnt_d;
  logic               fl_on_q, fl_on_d;
  logic [NUM_DIR-1:0] green_d, yellow_d, red_d;
  logic [NUM_DIR-1:0] sel_q, sel_d;
  logic               other, min_ok;
  logic [AW-1:0]      next_dir, cand;
  logic               found;

  // Round-robin search for the next requesting direction after dir_q
  always_comb begin
    next_dir = AW'((32'(dir_q) + 32'd1) % NUM_DIR);
    found    = 1'b0;
    cand     = '0;
    for (int unsigned k = 1; k <= NUM_DIR; k++) begin
      cand = AW'((32'(dir_q) + k) % NUM_DIR);
      if (!found && car[cand]) begin
        next_dir = cand;
        found    = 1'b1;
      end
    end
  end

  // Next-state, timer, flash phase and next lamp values
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    active_d = active;
    timer_d  = timer_q;
    fl_cnt_d = '0;
    fl_on_d  = 1'b1;
    green_d  = '0;
    yellow_d = '0;
    red_d    = '0;
    sel_q    = NUM_DIR'(1) << dir_q;
    other    = |(car & ~sel_q);
    min_ok   = (timer_q >= MIN_M1);

    case (state_q)
      ST_G: begin
        if ((flash && min_ok) ||
            (other && ((min_ok && !car[dir_q]) || (timer_q == MAX_M1))))
          state_d = ST_Y;
      end
      ST_Y: begin
        if (timer_q == Y_M1) state_d = ST_AR;
      end
      ST_AR: begin
        if (timer_q == AR_M1) begin
          if (flash) begin
            state_d = ST_FL;
          end else begin
            state_d  = ST_G;
            dir_d    = next_dir;
            active_d = next_dir;
          end
        end
      end
      ST_FL: begin
        if (!flash) begin
          state_d = ST_AR;
          dir_d   = LAST;
        end
      end
      default: state_d = ST_AR;
    endcase

    if (state_d != state_q)     timer_d = '0;
    else if (timer_q != TMR_MAX) timer_d = timer_q + CNT_W'(1);

    // Flash phase: YELLOW_T cycles on, YELLOW_T cycles off, starting on
    if (state_d == ST_FL && state_q == ST_FL) begin
      if (fl_cnt_q == Y_M1) begin
        fl_cnt_d = '0;
        fl_on_d  = !fl_on_q;
      end else begin
        fl_cnt_d = fl_cnt_q + CNT_W'(1);
        fl_on_d  = fl_on_q;
      end
    end

    sel_d = NUM_DIR'(1) << dir_d;
    case (state_d)
      ST_G:    begin green_d  = sel_d; red_d = ~sel_d; end
      ST_Y:    begin yellow_d = sel_d; red_d = ~sel_d; end
      ST_FL:   yellow_d = fl_on_d ? '1 : '0;
      default: red_d = '1;
    endcase
  end

  // State register and registered lamp/active outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_AR;
      timer_q  <= '0;
      dir_q    <= LAST;
      active   <= '0;
      fl_cnt_q <= '0;
      fl_on_q  <= 1'b1;
      green    <= '0;
      yellow   <= '0;
      red      <= '1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      dir_q    <= dir_d;
      active   <= active_d;
      fl_cnt_q <= fl_cnt_d;
      fl_on_q  <= fl_on_d;
      green    <= green_d;
      yellow   <= yellow_d;
      red      <= red_d;
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: a phase/elapsed-time reference
// model predicts lamps each cycle; a monitor compares on the falling edge.
module tb_traffic_light_ctrl;

  localparam int N    = 4;
  localparam int AW   = 2;
  localparam int GMIN = 10;
  localparam int GMAX = 40;
  localparam int YT   = 4;
  localparam int ART  = 2;
  localparam int K_G = 0, K_Y = 1, K_AR = 2, K_FL = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  car;
  logic          flash;
  logic [N-1:0]  green, yellow, red;
  logic [AW-1:0] active;

  traffic_light_ctrl #(
    .NUM_DIR(N), .CNT_W(8), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
    .YELLOW_T(YT), .ALLRED_T(ART)
  ) dut (
    .clk(clk), .rst_n(rst_n), .car(car), .flash(flash),
    .green(green), .yellow(yellow), .red(red), .active(active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  g;
    logic [N-1:0]  y;
    logic [N-1:0]  r;
    logic [AW-1:0] a;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  bit   run   = 1'b1;

  // Reference model: current phase, cycles spent in it, granted direction
  int m_kind  = K_AR;
  int m_el    = 0;
  int m_dir   = N - 1;
  int m_shown = 0;

  function automatic int rr_pick(input int c, input int from);
    for (int k = 1; k <= N; k++)
      if (((c >> ((from + k) % N)) & 1) != 0) return (from + k) % N;
    return (from + 1) % N;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    int all, sel;
    all = (1 << N) - 1;
    sel = 1 << m_dir;
    e.g = '0; e.y = '0; e.r = '0;
    e.a = AW'(m_shown);
    case (m_kind)
      K_G:  begin e.g = N'(sel); e.r = N'(all & ~sel); end
      K_Y:  begin e.y = N'(sel); e.r = N'(all & ~sel); end
      K_AR: e.r = N'(all);
      default: e.y = (((m_el / YT) % 2) == 0) ? N'(all) : '0;
    endcase
    return e;
  endfunction

  task automatic model_reset();
    m_kind = K_AR; m_el = 0; m_dir = N - 1; m_shown = 0;
  endtask

  task automatic model_step(input int c, input bit f);
    int  nk;
    bit  other, here, min_ok;
    nk     = m_kind;
    other  = (c & ~(1 << m_dir)) != 0;
    here   = ((c >> m_dir) & 1) != 0;
    min_ok = m_el >= GMIN - 1;
    case (m_kind)
      K_G:  if ((f && min_ok) || (other && ((min_ok && !here) || m_el == GMAX - 1))) nk = K_Y;
      K_Y:  if (m_el == YT - 1) nk = K_AR;
      K_AR: if (m_el == ART - 1) begin
              if (f) nk = K_FL;
              else begin
                nk = K_G;
                m_dir = rr_pick(c, m_dir);
                m_shown = m_dir;
              end
            end
      default: if (!f) begin nk = K_AR; m_dir = N - 1; end
    endcase
    if (nk != m_kind) m_el = 0;
    else m_el = m_el + 1;
    m_kind = nk;
  endtask

  // Predict the response to each clock edge (or asynchronous reset)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
      exp_q.delete();
      exp_q.push_back(expect_now());
    end else begin
      model_step(int'(car), flash);
      exp_q.push_back(expect_now());
    end
  end

  // Compare DUT outputs against the oldest prediction
  always @(negedge clk) begin
    if (run) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL underflow t=%0t no expected value queued", $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (green !== mon_e.g || yellow !== mon_e.y || red !== mon_e.r || active !== mon_e.a) begin
          bad++;
          $display("FAIL lamps t=%0t green=%b want %b yellow=%b want %b red=%b want %b active=%0d want %0d",
                   $time, green, mon_e.g, yellow, mon_e.y, red, mon_e.r, active, mon_e.a);
        end
      end
    end
  end

  // Assert reset mid-cycle and check outputs before any clock edge
  task automatic hit_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (red !== 4'b1111 || green !== 4'b0000 || yellow !== 4'b0000 || active !== 2'd0) begin
      bad++;
      $display("FAIL async_rst t=%0t green=%b yellow=%b red=%b active=%0d want 0000/0000/1111/0",
               $time, green, yellow, red, active);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; car = '0; flash = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (110) @(negedge clk);

    // Fresh green on dir0, then demand on dir2 from its first green cycle
    @(posedge clk);
    hit_reset();
    repeat (2) @(negedge clk);
    car = 4'b0100;
    repeat (30) @(negedge clk);

    // Competing demand held: max-green path; then wrap-around; then flash
    car = 4'b0011;
    repeat (120) @(negedge clk);
    car = 4'b1001;
    repeat (20) @(negedge clk);
    car = 4'b0001;
    repeat (30) @(negedge clk);
    car = 4'b0000;
    flash = 1'b1;
    repeat (40) @(negedge clk);
    flash = 1'b0;
    repeat (20) @(negedge clk);

    // Reset on the second yellow cycle
    car = 4'b0010;
    for (int i = 0; i < 60 && yellow == 4'b0000; i++) @(negedge clk);
    total++;
    if (yellow == 4'b0000) begin
      bad++;
      $display("FAIL reach_yellow yellow=%b want nonzero", yellow);
    end
    @(posedge clk);
    car = 4'b0000;
    hit_reset();
    repeat (20) @(negedge clk);

    // Randomised demand, flash requests and occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(11) == 0) car = N'($urandom);
      if ($urandom_range(149) == 0) flash = ~flash;
      if ($urandom_range(699) == 0) begin
        @(posedge clk);
        hit_reset();
      end
    end

    @(negedge clk);
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameter NUM_DIR, 4, number of approaches; legal range 2..8.
REQ-002 Parameter CNT_W, 8, phase timer width in bits.
REQ-003 Parameter GREEN_MIN, 10, minimum green length in cycles; 1 <= GREEN_MIN <= GREEN_MAX.
REQ-004 Parameter GREEN_MAX, 40, maximum green length in cycles while another direction has demand; GREEN_MAX < 2^CNT_W.
REQ-005 Parameter YELLOW_T, 4, yellow length in cycles, and the flash half-period; >= 1.
REQ-006 Parameter ALLRED_T, 2, all-red clearance length in cycles; >= 1.
REQ-007 Port Clock  in  1  system clock; all state changes on its rising edge.
REQ-008 Port Reset  in  1  asynchronous, active-low reset.
REQ-009 Port CAR  in  NUM_DIR  per-direction vehicle demand, level-sensitive, sampled every cycle.
REQ-010 Port FLASH  in  1  request to enter flashing-yellow mode, level-sensitive.
REQ-011 Port GREEN  out  NUM_DIR  per-direction green lamp.
REQ-012 Port YELLOW  out  NUM_DIR  per-direction yellow lamp.
REQ-013 Port RED  out  NUM_DIR  per-direction red lamp.
REQ-014 Port ACTIVE  out  clog2(NUM_DIR)  index of the direction currently or last granted.

Function
REQ-015 FSM states: G (green), Y (yellow), AR (all-red), FL (flash).
REQ-016 Phase timer is cleared to 0 on every state entry, increments each cycle, and saturates at all-ones.
REQ-017 Lamps are a pure function of the registered state, ACTIVE and the flash phase; they change on the same edge as the state, with no combinational path from the inputs.
REQ-018 In G: GREEN[ACTIVE]=1, all other directions RED=1.
REQ-019 In Y: YELLOW[ACTIVE]=1, all other directions RED=1.
REQ-020 In AR: RED is all ones.
REQ-021 In FL: GREEN=0 and RED=0; YELLOW is all ones for YELLOW_T cycles, then all zeros for YELLOW_T cycles, repeating, starting with ones.
REQ-022 Outside FL, exactly one lamp per direction is lit every cycle.
REQ-023 Let OTHER = |(CAR & ~onehot(ACTIVE)).
REQ-024 G -> Y when FLASH=1 and timer >= GREEN_MIN-1.
REQ-025 G -> Y when OTHER=1 and either (timer >= GREEN_MIN-1 and CAR[ACTIVE]=0) or timer == GREEN_MAX-1.
REQ-026 Otherwise G holds indefinitely, including when OTHER=0.
REQ-027 Y -> AR after exactly YELLOW_T cycles in Y.
REQ-028 AR -> FL after exactly ALLRED_T cycles if FLASH=1.
REQ-029 AR -> G after exactly ALLRED_T cycles if FLASH=0; ACTIVE is loaded on that edge.
REQ-030 New ACTIVE = first index with CAR set, searching round-robin from ACTIVE+1 with wrap-around modulo NUM_DIR and CAR sampled on the final AR cycle; if CAR=0, new ACTIVE = (ACTIVE+1) mod NUM_DIR.
REQ-031 FL -> AR when FLASH=0, on any cycle; ACTIVE is forced to NUM_DIR-1 so that direction 0 has first priority.
REQ-032 FLASH and CAR changes arriving in the same cycle: FLASH takes precedence in G.

Reset
REQ-033 While Reset=0: state=AR, timer=0, ACTIVE=NUM_DIR-1 internally, ACTIVE output=0, RED=all ones, GREEN=0, YELLOW=0, applied asynchronously.
REQ-034 After release: AR for ALLRED_T cycles, then G with ACTIVE chosen per REQ-030; with no demand this is direction 0.
REQ-035 Reset asserted in any state, including mid-Y or mid-FL, aborts the phase immediately.

Verification (defaults, NUM_DIR=4)
REQ-036 Release reset with CAR=0 -> RED=1111 for 2 cycles, then GREEN=0001, held for 100+ cycles.
REQ-037 Dir0 green with CAR=0100 -> GREEN=0001 for exactly 10 cycles, YELLOW=0001 for 4 cycles, RED=1111 for 2 cycles, then GREEN=0100 and ACTIVE=2.
REQ-038 Dir0 green with CAR=0011 held -> GREEN=0001 for exactly 40 cycles, Y for 4, AR for 2, then GREEN=0010.
REQ-039 ACTIVE=3 green, CAR=1001 with CAR[3] dropped after the minimum -> next GREEN=0001 (wrap-around).
REQ-040 FLASH=1 during green past the minimum -> Y 4 cycles, AR 2 cycles, then YELLOW alternates 1111/0000 every 4 cycles; FLASH=0 -> AR 2 cycles, then GREEN=0001 if CAR=0.
REQ-041 Reset=0 on the 2nd Y cycle -> RED=1111 immediately with no clock edge, ACTIVE=0; after release the sequence matches REQ-036.
